// File: rtl/led_arbiter_if.sv
// led_arbiter_if: request/LED/grant bundle between requesters and the LED arbiter
interface led_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_i;
  logic [4*N_REQ-1:0] leds_i;
  logic [N_REQ-1:0]   grant_o;
  logic [3:0]         leds_o;
  logic               busy_o;
  modport master (output req_i, leds_i, input grant_o, leds_o, busy_o);
  modport slave  (input req_i, leds_i, output grant_o, leds_o, busy_o);
endinterface

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin time-sliced sharing of four LEDs with a blank gap between owners
module led_arbiter #(
  parameter int N_REQ          = 4,
  parameter int QUANTUM_CLOCKS = 12000000,
  parameter int GAP_CLOCKS     = 1200000
) (
  input logic          clock,
  input logic          reset,
  led_arbiter_if.slave bus
);
  localparam int MAXC = QUANTUM_CLOCKS > GAP_CLOCKS ? QUANTUM_CLOCKS : GAP_CLOCKS;
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] Q_LAST = CW'(QUANTUM_CLOCKS - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CLOCKS > 0 ? GAP_CLOCKS - 1 : 0);
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;
  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    own_q, own_d, ptr_q, ptr_d, win, ptr_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             others, rel;
  logic [3:0]       leds;
  always_comb begin
    win = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req_i[(int'(ptr_q) + i) % N_REQ]) win = PW'((int'(ptr_q) + i) % N_REQ);
  end
  // a drop wins over expiry; expiry only preempts when someone else is waiting
  assign others   = |(bus.req_i & ~grant_q);
  assign rel      = !bus.req_i[own_q] || (cnt_q == Q_LAST && others);
  assign ptr_next = own_q == PW'(N_REQ - 1) ? '0 : own_q + 1'b1;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|bus.req_i) begin
        state_d = OWN;
        grant_d = N_REQ'(1) << win;
        own_d   = win;
        cnt_d   = '0;
      end
      OWN: if (rel) begin
        state_d = GAP_CLOCKS > 0 ? GAP : IDLE;
        grant_d = '0;
        ptr_d   = ptr_next;
        cnt_d   = '0;
      end else cnt_d = cnt_q == Q_LAST ? cnt_q : cnt_q + 1'b1;
      GAP: begin
        state_d = cnt_q == G_LAST ? IDLE : GAP;
        cnt_d   = cnt_q == G_LAST ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    leds = '0;
    for (int k = 0; k < N_REQ; k++) leds = leds | (bus.leds_i[4*k +: 4] & {4{grant_q[k]}});
  end
  assign bus.leds_o  = leds;
  assign bus.grant_o = grant_q;
  assign bus.busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed scenarios for led_arbiter with N_REQ=4, QUANTUM=8, GAP=2
module tb_led_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   asserts = 0;
  int   fails = 0;
  led_arbiter_if #(.N_REQ(4)) bus ();
  led_arbiter #(.N_REQ(4), .QUANTUM_CLOCKS(8), .GAP_CLOCKS(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic apply_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset;
    bus.req_i = 4'b1111;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++;
      if (bus.grant_o !== 4'b0000 || bus.leds_o !== 4'h0 || bus.busy_o !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: grant=%b leds=%h busy=%b, want 0000 0 0", i, bus.grant_o, bus.leds_o, bus.busy_o);
      end
    end
    reset = 1'b0;
    tick();
    asserts++;
    if (bus.grant_o !== 4'b0001 || bus.leds_o !== 4'h1 || bus.busy_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_grant: grant=%b leds=%h busy=%b, want 0001 1 1", bus.grant_o, bus.leds_o, bus.busy_o);
    end
  endtask
  task automatic test_lone_owner;
    apply_reset();
    bus.req_i = 4'b0100;
    tick();
    for (int i = 0; i < 50; i++) begin
      asserts++;
      if (bus.grant_o !== 4'b0100 || bus.leds_o !== 4'hA) begin
        fails++;
        $display("FAIL lone_owner[%0d]: grant=%b leds=%h, want 0100 a", i, bus.grant_o, bus.leds_o);
      end
      tick();
    end
  endtask
  task automatic test_round_robin;
    logic [3:0] tbl [4];
    logic [3:0] eg, el;
    int ph, ow;
    tbl = '{4'h1, 4'h2, 4'hA, 4'h4};
    apply_reset();
    bus.req_i = 4'b1111;
    tick();
    for (int s = 0; s < 45; s++) begin
      ph = s % 11;
      ow = (s / 11) % 4;
      eg = ph < 8 ? 4'(1 << ow) : 4'b0000;
      el = ph < 8 ? tbl[ow] : 4'h0;
      asserts++;
      if (bus.grant_o !== eg || bus.leds_o !== el) begin
        fails++;
        $display("FAIL round_robin[%0d]: grant=%b leds=%h, want %b %h", s, bus.grant_o, bus.leds_o, eg, el);
      end
      tick();
    end
  endtask
  task automatic test_drop;
    logic [3:0] exp_g [4];
    logic       exp_b [4];
    exp_g = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
    exp_b = '{1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    bus.req_i = 4'b0011;
    tick();
    tick();
    tick();
    asserts++;
    if (bus.grant_o !== 4'b0001) begin
      fails++;
      $display("FAIL drop_owned: grant=%b, want 0001", bus.grant_o);
    end
    bus.req_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      asserts++;
      if (bus.grant_o !== exp_g[i] || bus.busy_o !== exp_b[i]) begin
        fails++;
        $display("FAIL drop_seq[%0d]: grant=%b busy=%b, want %b %b", i, bus.grant_o, bus.busy_o, exp_g[i], exp_b[i]);
      end
    end
  endtask
  task automatic test_reset_mid_own;
    apply_reset();
    bus.req_i = 4'b0010;
    tick();
    bus.req_i = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    asserts++;
    if (bus.grant_o !== 4'b0100) begin
      fails++;
      $display("FAIL midown_setup: grant=%b, want 0100", bus.grant_o);
    end
    reset = 1'b1;
    bus.req_i = 4'b0101;
    tick();
    asserts++;
    if (bus.grant_o !== 4'b0000 || bus.leds_o !== 4'h0 || bus.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL midown_reset: grant=%b leds=%h busy=%b, want 0000 0 0", bus.grant_o, bus.leds_o, bus.busy_o);
    end
    reset = 1'b0;
    tick();
    asserts++;
    if (bus.grant_o !== 4'b0001) begin
      fails++;
      $display("FAIL midown_ptr: grant=%b, want 0001", bus.grant_o);
    end
  endtask
  task automatic test_late_preempt;
    apply_reset();
    bus.req_i = 4'b0001;
    tick();
    for (int i = 0; i < 20; i++) tick();
    asserts++;
    if (bus.grant_o !== 4'b0001 || bus.leds_o !== 4'h1) begin
      fails++;
      $display("FAIL late_hold: grant=%b leds=%h, want 0001 1", bus.grant_o, bus.leds_o);
    end
    bus.req_i = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++;
      if (bus.grant_o !== 4'b0000 || bus.leds_o !== 4'h0) begin
        fails++;
        $display("FAIL late_gap[%0d]: grant=%b leds=%h, want 0000 0", i, bus.grant_o, bus.leds_o);
      end
    end
    tick();
    asserts++;
    if (bus.grant_o !== 4'b1000 || bus.leds_o !== 4'h4) begin
      fails++;
      $display("FAIL late_grant: grant=%b leds=%h, want 1000 4", bus.grant_o, bus.leds_o);
    end
  endtask
  initial begin
    bus.req_i  = '0;
    bus.leds_i = 16'h4A21;
    test_reset();
    test_lone_owner();
    test_round_robin();
    test_drop();
    test_reset_mid_own();
    test_late_preempt();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
